// File: rtl/tbcm_weighted_matrix_arbiter_if.sv
// Request/grant bundle of the weighted matrix arbiter: requests, completion strobes,
// per-requester weights in, grant state out.
interface tbcm_weighted_matrix_arbiter_if #(
    parameter int REQUESTS     = 4,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int IW = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;

    logic [REQUESTS-1:0]                   i_request;
    logic [REQUESTS-1:0]                   i_free;
    logic [REQUESTS-1:0][WEIGHT_WIDTH-1:0] i_weight;
    logic [REQUESTS-1:0]                   o_grant;
    logic [IW-1:0]                         o_grant_index;
    logic                                  o_busy;
    logic [WEIGHT_WIDTH-1:0]               o_remaining;

    modport master (
        output i_request, i_free, i_weight,
        input  o_grant, o_grant_index, o_busy, o_remaining
    );

    modport slave (
        input  i_request, i_free, i_weight,
        output o_grant, o_grant_index, o_busy, o_remaining
    );
endinterface

// File: rtl/tbcm_weighted_matrix_arbiter.sv
// Weighted matrix arbiter: a winner holds the grant for up to weight+1 completed transactions.
// Optional busy timeout enabled by defining TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN.
package tbcm_matrix_arbiter_pkg;
    typedef enum logic [1:0] {
        TBCM_MATRIX_ARBITER_INCREMENTAL_RR = 2'd0,
        TBCM_MATRIX_ARBITER_DECREMENTAL_RR = 2'd1,
        TBCM_MATRIX_ARBITER_LRG            = 2'd2,
        TBCM_MATRIX_ARBITER_MRG            = 2'd3
    } tbcm_matrix_arbiter_type;
endpackage

module tbcm_weighted_matrix_arbiter
    import tbcm_matrix_arbiter_pkg::*;
#(
    parameter int                                REQUESTS         = 4,
    parameter int                                WEIGHT_WIDTH     = 4,
    parameter logic [REQUESTS-1:0][REQUESTS-1:0] INITIAL_PRIORITY = '1,
    parameter int                                TIMEOUT_CYCLES   = 256
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_reset_priority,
    input  logic [REQUESTS-1:0][REQUESTS-1:0] i_initial_priority,
    input  tbcm_matrix_arbiter_type           i_arbiter_type,
`ifdef TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN
    output logic                              o_timeout,
`endif
    tbcm_weighted_matrix_arbiter_if.slave     bus
);
    localparam int NU = REQUESTS * (REQUESTS - 1) / 2;
    localparam int IW = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    // Flat position of upper-triangle element (i,j), i<j, row-major.
    function automatic int uidx(input int i, input int j);
        return i * REQUESTS - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    function automatic logic [NU-1:0] pack_upper(input logic [REQUESTS-1:0][REQUESTS-1:0] m);
        logic [NU-1:0] u;
        u = '0;
        for (int i = 0; i < REQUESTS; i++)
            for (int j = i + 1; j < REQUESTS; j++)
                u[uidx(i, j)] = m[i][j];
        return u;
    endfunction

    function automatic logic [NU-1:0] update_upper(input logic [NU-1:0] cur,
                                                   input logic [REQUESTS-1:0] g,
                                                   input tbcm_matrix_arbiter_type t);
        logic [NU-1:0] u;
        int            gi;
        u  = cur;
        gi = 0;
        for (int k = 0; k < REQUESTS; k++)
            if (g[k]) gi = k;
        for (int i = 0; i < REQUESTS; i++)
            for (int j = i + 1; j < REQUESTS; j++)
                case (t)
                    TBCM_MATRIX_ARBITER_LRG: begin
                        if (g[i])      u[uidx(i, j)] = 1'b0;
                        else if (g[j]) u[uidx(i, j)] = 1'b1;
                    end
                    TBCM_MATRIX_ARBITER_MRG: begin
                        if (g[i])      u[uidx(i, j)] = 1'b1;
                        else if (g[j]) u[uidx(i, j)] = 1'b0;
                    end
                    // Rotations: the neighbour after (or before) the winner becomes highest.
                    TBCM_MATRIX_ARBITER_INCREMENTAL_RR: u[uidx(i, j)] = !(i <= gi && j > gi);
                    default:                            u[uidx(i, j)] = (i < gi && j >= gi);
                endcase
        return u;
    endfunction

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [NU-1:0]           r_upper;
    logic [REQUESTS-1:0]     r_grant;
    logic [WEIGHT_WIDTH-1:0] r_cnt;
    logic [WEIGHT_WIDTH-1:0] w_cnt_nxt;
    logic [REQUESTS-1:0]     w_blocked;
    logic [REQUESTS-1:0]     w_idle_grant;
    logic [REQUESTS-1:0]     w_grant;
    logic [REQUESTS-1:0]     w_rel_grant;
    logic [WEIGHT_WIDTH-1:0] w_sel_weight;
    logic [IW-1:0]           w_grant_index;
    logic                    w_latch;
    logic                    w_release;
    logic                    w_free_hit;
    logic                    w_req_hit;
    logic                    w_unused;

    // Lower triangle and diagonal of the reload matrix are implied by the upper triangle.
    assign w_unused = ^{i_initial_priority, TIMEOUT_CYCLES};

    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < REQUESTS; i++)
            for (int j = 0; j < REQUESTS; j++) begin
                if (j < i) begin
                    if (r_upper[uidx(j, i)] && bus.i_request[j]) w_blocked[i] = 1'b1;
                end else if (j > i) begin
                    if (!r_upper[uidx(i, j)] && bus.i_request[j]) w_blocked[i] = 1'b1;
                end
            end
    end

    assign w_idle_grant = rst ? '0 : (bus.i_request & ~w_blocked);
    assign w_free_hit   = |(r_grant & bus.i_free);
    assign w_req_hit    = |(r_grant & bus.i_request);

    always_comb begin
        w_sel_weight = '0;
        for (int k = 0; k < REQUESTS; k++)
            if (w_idle_grant[k]) w_sel_weight = w_sel_weight | bus.i_weight[k];
    end

`ifdef TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;
    logic            w_force;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_release   = 1'b0;
        w_rel_grant = r_grant;
        w_cnt_nxt   = r_cnt;
`ifdef TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN
        w_force     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                w_rel_grant = w_idle_grant;
                w_cnt_nxt   = '0;
                if (|w_idle_grant) begin
                    if (|(w_idle_grant & bus.i_free)) begin
                        if (w_sel_weight == '0) begin
                            w_release = 1'b1;
                        end else begin
                            w_latch     = 1'b1;
                            w_state_nxt = BUSY;
                            w_cnt_nxt   = w_sel_weight - WEIGHT_WIDTH'(1);
                        end
                    end else begin
                        w_latch     = 1'b1;
                        w_state_nxt = BUSY;
                        w_cnt_nxt   = w_sel_weight;
                    end
                end
            end
            BUSY: begin
                if (w_free_hit) begin
                    if (r_cnt == '0 || !w_req_hit) begin
                        w_release   = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - WEIGHT_WIDTH'(1);
                    end
                end
`ifdef TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN
                else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    w_force     = 1'b1;
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reload beats a release update; neither touches the latched grant or the counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
            r_upper <= pack_upper(INITIAL_PRIORITY);
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_latch) r_grant <= w_idle_grant;
            if (i_reset_priority)
                r_upper <= pack_upper(i_initial_priority);
            else if (w_release)
                r_upper <= update_upper(r_upper, w_rel_grant, i_arbiter_type);
        end
    end

`ifdef TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_force;
            if (r_state == BUSY && w_state_nxt == BUSY && !w_free_hit)
                r_to_cnt <= r_to_cnt + TO_W'(1);
            else
                r_to_cnt <= '0;
        end
    end

    assign o_timeout = r_timeout;
`endif

    assign w_grant = (r_state == BUSY) ? r_grant : w_idle_grant;

    always_comb begin
        w_grant_index = '0;
        for (int k = 0; k < REQUESTS; k++)
            if (w_grant[k]) w_grant_index = IW'(k);
    end

    assign bus.o_grant       = w_grant;
    assign bus.o_grant_index = w_grant_index;
    assign bus.o_busy        = (r_state == BUSY);
    assign bus.o_remaining   = (r_state == BUSY) ? r_cnt : '0;
endmodule

// File: tb/tb_tbcm_weighted_matrix_arbiter.sv
// Table-driven scoreboard bench for tbcm_weighted_matrix_arbiter (REQUESTS=4, WEIGHT_WIDTH=4).
module tb_tbcm_weighted_matrix_arbiter;
    import tbcm_matrix_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int WW = 4;
    localparam int TO = 8;

    typedef struct {
        logic [N-1:0]            req;
        logic [N-1:0]            free;
        logic [N-1:0][WW-1:0]    w;
        logic                    rp;
        logic [N-1:0][N-1:0]     init;
        tbcm_matrix_arbiter_type t;
        logic [N-1:0]            eg;
        logic                    eb;
        logic [WW-1:0]           er;
    } vec_t;

    typedef struct {
        logic [N-1:0]  g;
        logic          b;
        logic [WW-1:0] r;
        int            id;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    rp;
    logic [N-1:0][N-1:0]     init;
    tbcm_matrix_arbiter_type atype;
`ifdef TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN
    logic                    timeout;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t tbl[$];
    exp_t sb[$];

    tbcm_weighted_matrix_arbiter_if #(.REQUESTS(N), .WEIGHT_WIDTH(WW)) bus ();

    tbcm_weighted_matrix_arbiter #(
        .REQUESTS(N), .WEIGHT_WIDTH(WW), .INITIAL_PRIORITY('1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_reset_priority(rp),
        .i_initial_priority(init),
        .i_arbiter_type(atype),
`ifdef TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN
        .o_timeout(timeout),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [N-1:0] g);
        int r;
        r = 0;
        for (int k = 0; k < N; k++)
            if (g[k]) r = k;
        return r;
    endfunction

    task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] req, input logic [N-1:0] free, input logic [15:0] w,
                       input logic r, input logic [15:0] im, input tbcm_matrix_arbiter_type t,
                       input logic [N-1:0] eg, input logic eb, input logic [WW-1:0] er);
        vec_t v;
        v.req = req; v.free = free; v.w = w; v.rp = r; v.init = im; v.t = t;
        v.eg = eg; v.eb = eb; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic sample();
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: no expected entry, got grant %0h", bus.o_grant);
            return;
        end
        e = sb.pop_front();
        check("grant",       e.id, 32'(bus.o_grant),       32'(e.g));
        check("grant_index", e.id, 32'(bus.o_grant_index), 32'(idx_of(e.g)));
        check("busy",        e.id, 32'(bus.o_busy),        32'(e.b));
        check("remaining",   e.id, 32'(bus.o_remaining),   32'(e.r));
    endtask

    task automatic apply(input vec_t v, input int id);
        @(posedge clk);
        #1;
        bus.i_request = v.req;
        bus.i_free    = v.free;
        bus.i_weight  = v.w;
        rp            = v.rp;
        init          = v.init;
        atype         = v.t;
        sb.push_back('{g: v.eg, b: v.eb, r: v.er, id: id});
        @(negedge clk);
        sample();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   id;
        localparam tbcm_matrix_arbiter_type L = TBCM_MATRIX_ARBITER_LRG;
        localparam tbcm_matrix_arbiter_type M = TBCM_MATRIX_ARBITER_MRG;
        localparam tbcm_matrix_arbiter_type I = TBCM_MATRIX_ARBITER_INCREMENTAL_RR;
        localparam tbcm_matrix_arbiter_type D = TBCM_MATRIX_ARBITER_DECREMENTAL_RR;

        // LRG, weights 0, all requesting, free every cycle
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, L, 4'b0001, 0, 0);
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, L, 4'b0010, 0, 0);
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, L, 4'b0100, 0, 0);
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, L, 4'b1000, 0, 0);
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, L, 4'b0001, 0, 0);
        // reload priority, then w0=2: three transactions for 0, one for 1
        add(4'b0000, 4'b0000, 16'h0000, 1, 16'hFFFF, L, 4'b0000, 0, 0);
        add(4'b0011, 4'b0000, 16'h0002, 0, 16'h0, L, 4'b0001, 0, 0);
        add(4'b0011, 4'b0001, 16'h0002, 0, 16'h0, L, 4'b0001, 1, 2);
        add(4'b0011, 4'b0001, 16'h0002, 0, 16'h0, L, 4'b0001, 1, 1);
        add(4'b0011, 4'b0001, 16'h0002, 0, 16'h0, L, 4'b0001, 1, 0);
        add(4'b0011, 4'b0010, 16'h0002, 0, 16'h0, L, 4'b0010, 0, 0);
        // w0=3, request dropped with the first free: early release
        add(4'b0011, 4'b0000, 16'h0003, 0, 16'h0, L, 4'b0001, 0, 0);
        add(4'b0010, 4'b0001, 16'h0003, 0, 16'h0, L, 4'b0001, 1, 3);
        add(4'b0010, 4'b0000, 16'h0003, 0, 16'h0, L, 4'b0010, 0, 0);
        add(4'b0000, 4'b0010, 16'h0003, 0, 16'h0, L, 4'b0010, 1, 0);
        // grant 0100 held against foreign request/free and priority reload
        add(4'b0100, 4'b0000, 16'h0200, 0, 16'h0, L, 4'b0100, 0, 0);
        add(4'b0101, 4'b0001, 16'h0200, 0, 16'h0, L, 4'b0100, 1, 2);
        add(4'b0100, 4'b0000, 16'h0200, 1, 16'h0, L, 4'b0100, 1, 2);
        add(4'b1011, 4'b0100, 16'h0200, 1, 16'h0, L, 4'b0100, 1, 2);
        add(4'b1111, 4'b1000, 16'h0000, 0, 16'h0, L, 4'b1000, 0, 0);
        add(4'b0111, 4'b0100, 16'h0000, 0, 16'h0, L, 4'b0100, 0, 0);
        // incremental round robin
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, I, 4'b0010, 0, 0);
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, I, 4'b0100, 0, 0);
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, I, 4'b1000, 0, 0);
        add(4'b0101, 4'b0101, 16'h0000, 0, 16'h0, I, 4'b0001, 0, 0);
        add(4'b0101, 4'b0101, 16'h0000, 0, 16'h0, I, 4'b0100, 0, 0);
        // decremental round robin
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, D, 4'b1000, 0, 0);
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, D, 4'b0100, 0, 0);
        add(4'b1111, 4'b1111, 16'h0000, 0, 16'h0, D, 4'b0010, 0, 0);
        add(4'b0110, 4'b0110, 16'h0000, 0, 16'h0, D, 4'b0100, 0, 0);
        add(4'b0110, 4'b0110, 16'h0000, 0, 16'h0, D, 4'b0010, 0, 0);
        // most recently granted
        add(4'b0011, 4'b0011, 16'h0000, 0, 16'h0, M, 4'b0001, 0, 0);
        add(4'b0011, 4'b0011, 16'h0000, 0, 16'h0, M, 4'b0001, 0, 0);
        add(4'b0110, 4'b0000, 16'h0000, 0, 16'h0, M, 4'b0100, 0, 0);
        add(4'b0110, 4'b0000, 16'h0000, 0, 16'h0, M, 4'b0100, 1, 0);
        add(4'b0110, 4'b0100, 16'h0000, 0, 16'h0, M, 4'b0100, 1, 0);
        add(4'b0110, 4'b0100, 16'h0000, 0, 16'h0, M, 4'b0100, 0, 0);

        bus.i_request = '0;
        bus.i_free    = '0;
        bus.i_weight  = '0;
        rp            = 1'b0;
        init          = '0;
        atype         = L;

        @(negedge clk);
        check("reset_grant",     0, 32'(bus.o_grant),       32'd0);
        check("reset_index",     0, 32'(bus.o_grant_index), 32'd0);
        check("reset_busy",      0, 32'(bus.o_busy),        32'd0);
        check("reset_remaining", 0, 32'(bus.o_remaining),   32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        id = 1;
        foreach (tbl[k]) begin
            apply(tbl[k], id);
            id++;
        end

        // maximum weight: 16 transactions, remaining counts 15 down to 0
        v = '{req: 4'b0001, free: 4'b0000, w: 16'h000F, rp: 1'b0, init: '0, t: L,
              eg: 4'b0001, eb: 1'b0, er: 4'd0};
        apply(v, id++);
        for (int k = 0; k < 16; k++) begin
            v.free = 4'b0001;
            v.eb   = 1'b1;
            v.er   = WW'(15 - k);
            apply(v, id++);
        end
        v = '{req: 4'b0000, free: 4'b0000, w: 16'h0000, rp: 1'b0, init: '0, t: L,
              eg: 4'b0000, eb: 1'b0, er: 4'd0};
        apply(v, id++);

        // asynchronous reset while busy with five transactions left
        v = '{req: 4'b0001, free: 4'b0000, w: 16'h0005, rp: 1'b0, init: '0, t: L,
              eg: 4'b0001, eb: 1'b0, er: 4'd0};
        apply(v, id++);
        v.eb = 1'b1;
        v.er = 4'd5;
        apply(v, id++);
        #2 rst = 1'b1;
        #1;
        check("rst_busy_grant",     id, 32'(bus.o_grant),       32'd0);
        check("rst_busy_index",     id, 32'(bus.o_grant_index), 32'd0);
        check("rst_busy_busy",      id, 32'(bus.o_busy),        32'd0);
        check("rst_busy_remaining", id, 32'(bus.o_remaining),   32'd0);
        bus.i_request = '0;
        bus.i_free    = '0;
        bus.i_weight  = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        v = '{req: 4'b1111, free: 4'b0000, w: 16'h0000, rp: 1'b0, init: '0, t: L,
              eg: 4'b0001, eb: 1'b0, er: 4'd0};
        apply(v, id++);

`ifdef TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN
        // grant held without any free until the timeout forces a release
        v.eb = 1'b1;
        for (int k = 0; k < TO; k++) begin
            apply(v, id);
            check("timeout_quiet", id, 32'(timeout), 32'd0);
            id++;
        end
        v = '{req: 4'b0000, free: 4'b0000, w: 16'h0000, rp: 1'b0, init: '0, t: L,
              eg: 4'b0000, eb: 1'b0, er: 4'd0};
        apply(v, id);
        check("timeout_pulse", id, 32'(timeout), 32'd1);
        id++;
        v.req = 4'b1111;
        v.eg  = 4'b0010;
        apply(v, id);
        check("timeout_clear", id, 32'(timeout), 32'd0);
        id++;
`endif

        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: %0d expected entries never compared", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tbcm_weighted_matrix_arbiter.md
Name: tbcm_weighted_matrix_arbiter

Overview:
- Matrix arbiter with per-requester weights. A winner keeps its grant for up to weight+1 completed transactions (i_free pulses) before the priority matrix is updated and arbitration restarts.
- Supports the same four policies from tbcm_matrix_arbiter_pkg: incremental RR, decremental RR, LRG and MRG.
- Used as the bandwidth-shaping front end of shared buses and memory ports, where plain one-transaction-per-grant arbitration is too fine-grained.

Parameters:
- REQUESTS, 4, number of requesters (>=2).
- WEIGHT_WIDTH, 4, width of each per-requester weight field.
- INITIAL_PRIORITY, '1, REQUESTS x REQUESTS priority matrix loaded at reset. Only the upper triangle is used.
- TIMEOUT_CYCLES, 256, busy-timeout limit. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_reset_priority  in  1  reload the priority matrix from i_initial_priority.
- i_initial_priority  in  REQUESTS x REQUESTS  matrix used by i_reset_priority.
- i_arbiter_type  in  tbcm_matrix_arbiter_type  arbitration policy; must be static while busy.
- i_weight  in  REQUESTS x WEIGHT_WIDTH  per-requester extra transactions; sampled at grant capture.
- i_request  in  REQUESTS  request vector.
- i_free  in  REQUESTS  transaction-complete strobe; only the bit of the granted requester is honoured.
- o_grant  out  REQUESTS  one-hot grant, or all zero.
- o_grant_index  out  $clog2(REQUESTS)  binary index of o_grant; 0 when o_grant is zero.
- o_busy  out  1  grant is latched.
- o_remaining  out  WEIGHT_WIDTH  transactions left after the current one; 0 in IDLE.

Behaviour:
- Reset values: o_grant=0, o_grant_index=0, o_busy=0, o_remaining=0, state=IDLE, matrix=INITIAL_PRIORITY.
- Matrix storage:
  - Only the upper-triangle flops are stored.
  - Lower triangle = inverse of the upper triangle.
  - Diagonal = 1 for incremental RR, otherwise 0.
- Grant computation: requester i wins when it is requesting and no other requester j with matrix[j][i]=1 is also requesting.
- State machine, two states, IDLE and BUSY.
- IDLE:
  - o_grant = combinational winner of i_request, so the grant appears in the same cycle as the request (zero latency).
  - When any request is present, winner w:
    - If i_free[w]=1 and i_weight[w]=0: release at the clock edge (see Release) and stay IDLE.
    - If i_free[w]=1 and i_weight[w]>0: go BUSY with counter = i_weight[w]-1.
    - If i_free[w]=0: go BUSY with counter = i_weight[w].
  - Whenever BUSY is entered, the grant is latched.
- BUSY:
  - o_grant = latched grant. i_request is ignored for arbitration. o_busy=1, o_remaining=counter.
  - i_free[w]=1 and (counter==0 or i_request[w]=0): release and go IDLE.
  - i_free[w]=1 otherwise: counter decrements and state stays BUSY.
  - Requester w dropping its request without i_free: the grant is held, because the transaction in flight must complete.
  - i_free on non-granted bits: ignored.
- Release:
  - The matrix updates on the release edge, never at grant capture. The update uses the released grant vector:
    - LRG: winner becomes lowest priority.
    - MRG: winner becomes highest priority.
    - Incremental / decremental RR: rotate as in the existing matrix arbiter.
  - The next IDLE cycle arbitrates with the updated matrix, so there is no bubble beyond the one-cycle re-arbitration.
- Simultaneous events:
  - i_reset_priority has precedence over a release update on the same edge.
  - i_reset_priority never changes the latched grant or the counter.
- Widths:
  - Counter is WEIGHT_WIDTH bits and never wraps; decrement happens only when counter>0.
  - The maximum weight gives 2^WEIGHT_WIDTH transactions.
- Reset mid-BUSY: immediate return to the reset values; any in-flight transaction is abandoned.

Optional Feature:
- Macro: TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES+1)-bit counter counts BUSY cycles without i_free[w]; it is cleared on each honoured i_free.
  - Reaching TIMEOUT_CYCLES forces a release: normal priority update, IDLE next cycle.
  - Extra output o_timeout (1 bit) pulses for one cycle on the forced-release edge; reset value 0.
- Undefined: no counter, no o_timeout port; BUSY is held indefinitely until an honoured i_free.

Test Plan:
- REQUESTS=4, LRG, INITIAL_PRIORITY='1, weights all 0. i_request=4'b1111 held, i_free pulsed every cycle -> grants 0,1,2,3,0 in order, each one transaction; o_remaining stays 0.
- Weights {w0=2, w1=0}, i_request=4'b0011, i_free[0] pulsed on 3 cycles -> o_grant=0001 for 3 transactions with o_remaining 2,1,0, then 0010 for one transaction.
- Requester 0 granted with weight 3; it drops i_request after the first i_free -> release on that free, priority updated, requester 1 granted the next cycle.
- BUSY with grant 0100: toggle i_request[0], i_free[0], and i_reset_priority with i_initial_priority=0 -> o_grant stays 0100; after release, the matrix equals the reloaded value and requester 3 wins.
- Assert rst mid-BUSY with o_remaining=5 -> o_grant=0, o_busy=0, o_remaining=0 immediately; matrix back to INITIAL_PRIORITY.
- With TBCM_WEIGHTED_MATRIX_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=8: grant held with no i_free for 8 cycles -> o_timeout pulses once, o_grant=0 the next cycle, then the next requester is granted.
